// File: rtl/vme_env_pkg.sv
// ---------------------------------------------------------------------------
// vme_env_pkg
// Shared types for the VME controller environment:
//   master_state_t : bus-master FSM states
//   dev_state_t    : device-responder FSM states
//   TIMEOUT_DEF    : default dtack wait limit in cycles (8-bit counter)
//   err_cause_t    : error-cause codes, used by the testbench to label scenarios
// ---------------------------------------------------------------------------
package vme_env_pkg;

    localparam int TIMEOUT_DEF = 255;

    typedef enum logic [2:0] {
        M_IDLE,
        M_REQ,
        M_WACK,
        M_REL,
        M_WRACK,
        M_FIN,
        M_ERR
    } master_state_t;

    typedef enum logic [1:0] {
        D_LO,
        D_RISE,
        D_HI,
        D_FALL
    } dev_state_t;

    typedef enum logic [2:0] {
        ERR_NONE,
        ERR_TIMEOUT,
        ERR_LDS,
        ERR_DUAL,
        ERR_DTACK,
        ERR_RD_ORDER,
        ERR_WR_ORDER
    } err_cause_t;

endpackage

// File: rtl/vme_dev_resp.sv
// ---------------------------------------------------------------------------
// vme_dev_resp
// Device responder: answers lds events with ldtack events after LDTACK_DLY
// cycles. The ldtack pulse is registered at the LDTACK_DLY-th rising edge
// after the edge that sampled the lds event.
// Ports:
//   clk, reset                : clock, asynchronous active-high reset
//   lds_PLUS, lds_MINUS       : controller device-strobe events
//   ldtack_PLUS, ldtack_MINUS : registered one-cycle acknowledge pulses
//   dev_state                 : current FSM state (for the protocol checker)
// ---------------------------------------------------------------------------
module vme_dev_resp
    import vme_env_pkg::*;
#(
    parameter int LDTACK_DLY = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       lds_PLUS,
    input  logic       lds_MINUS,
    output logic       ldtack_PLUS,
    output logic       ldtack_MINUS,
    output dev_state_t dev_state
);

    localparam logic [3:0] DLY = 4'(LDTACK_DLY);

    logic [3:0] dly_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dev_state    <= D_LO;
            dly_cnt      <= '0;
            ldtack_PLUS  <= 1'b0;
            ldtack_MINUS <= 1'b0;
        end else begin
            ldtack_PLUS  <= 1'b0;
            ldtack_MINUS <= 1'b0;
            case (dev_state)
                D_LO: begin
                    if (lds_PLUS) begin
                        dly_cnt   <= DLY;
                        dev_state <= D_RISE;
                    end
                end
                D_RISE: begin
                    // count==1 means this decrement reaches zero
                    dly_cnt <= dly_cnt - 4'd1;
                    if (dly_cnt == 4'd1) begin
                        ldtack_PLUS <= 1'b1;
                        dev_state   <= D_HI;
                    end
                end
                D_HI: begin
                    if (lds_MINUS) begin
                        dly_cnt   <= DLY;
                        dev_state <= D_FALL;
                    end
                end
                D_FALL: begin
                    dly_cnt <= dly_cnt - 4'd1;
                    if (dly_cnt == 4'd1) begin
                        ldtack_MINUS <= 1'b1;
                        dev_state    <= D_LO;
                    end
                end
                default: dev_state <= D_LO;
            endcase
        end
    end

endmodule

// File: rtl/vme_env_sync.sv
// ---------------------------------------------------------------------------
// vme_env_sync
// Synchronous closed-loop environment for the clocked VME bus controller.
// Bus master issues dsr/dsw request events and waits for dtack events;
// device responder (vme_dev_resp) answers lds with ldtack; a protocol
// checker watches the controller outputs and sets a sticky error.
// Ports:
//   clk, reset                   : clock, asynchronous active-high reset
//   start, rnw                   : request one cycle (read when rnw=1)
//   d_*, lds_*, dtack_*          : controller event inputs (one-cycle pulses)
//   dsr_*, dsw_*                 : master request events (registered pulses)
//   ldtack_*                     : device acknowledge events (registered pulses)
//   busy, done, error            : master not idle / cycle complete / sticky error
//   cycle_count                  : completed cycles, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module vme_env_sync
    import vme_env_pkg::*;
#(
    parameter int LDTACK_DLY = 2,
    parameter int TIMEOUT    = TIMEOUT_DEF,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             rnw,
    input  logic             d_PLUS,
    input  logic             d_MINUS,
    input  logic             lds_PLUS,
    input  logic             lds_MINUS,
    input  logic             dtack_PLUS,
    input  logic             dtack_MINUS,
    output logic             dsr_PLUS,
    output logic             dsr_MINUS,
    output logic             dsw_PLUS,
    output logic             dsw_MINUS,
    output logic             ldtack_PLUS,
    output logic             ldtack_MINUS,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] cycle_count
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    master_state_t state;
    dev_state_t    dev_state;
    logic          rnw_q;
    logic [7:0]    tmo_cnt;
    logic          d_seen;

    logic early_ack;
    logic dual_evt;
    logic lds_bad;
    logic dtack_bad;
    logic order_bad;
    logic violation;

    vme_dev_resp #(
        .LDTACK_DLY(LDTACK_DLY)
    ) u_dev (
        .clk         (clk),
        .reset       (reset),
        .lds_PLUS    (lds_PLUS),
        .lds_MINUS   (lds_MINUS),
        .ldtack_PLUS (ldtack_PLUS),
        .ldtack_MINUS(ldtack_MINUS),
        .dev_state   (dev_state)
    );

    // An ack landing in the same cycle as our request/release pulse is
    // dropped by the FSM; flag it so the lost handshake is visible.
    assign early_ack = (state == M_REQ && dtack_PLUS) || (state == M_REL && dtack_MINUS);
    assign dual_evt  = (d_PLUS && d_MINUS) || (lds_PLUS && lds_MINUS) ||
                       (dtack_PLUS && dtack_MINUS);
    assign lds_bad   = (lds_PLUS && dev_state != D_LO) || (lds_MINUS && dev_state != D_HI);
    assign dtack_bad = (dtack_PLUS && state != M_WACK) || (dtack_MINUS && state != M_WRACK);
    // Data ordering: a same-cycle d_PLUS counts as already seen.
    assign order_bad = (state != M_IDLE) && !(d_seen || d_PLUS) &&
                       ((rnw_q && dtack_PLUS) || (!rnw_q && lds_PLUS));
    assign violation = early_ack || dual_evt || lds_bad || dtack_bad || order_bad;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= M_IDLE;
            rnw_q       <= 1'b0;
            tmo_cnt     <= '0;
            d_seen      <= 1'b0;
            dsr_PLUS    <= 1'b0;
            dsr_MINUS   <= 1'b0;
            dsw_PLUS    <= 1'b0;
            dsw_MINUS   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            cycle_count <= '0;
        end else begin
            dsr_PLUS  <= 1'b0;
            dsr_MINUS <= 1'b0;
            dsw_PLUS  <= 1'b0;
            dsw_MINUS <= 1'b0;
            done      <= 1'b0;

            if (violation)
                error <= 1'b1;

            if (state == M_IDLE)
                d_seen <= 1'b0;
            else if (d_PLUS)
                d_seen <= 1'b1;

            case (state)
                M_IDLE: begin
                    if (start) begin
                        rnw_q    <= rnw;
                        dsr_PLUS <= rnw;
                        dsw_PLUS <= !rnw;
                        busy     <= 1'b1;
                        state    <= M_REQ;
                    end
                end
                M_REQ: begin
                    tmo_cnt <= '0;
                    state   <= M_WACK;
                end
                M_WACK: begin
                    if (dtack_PLUS) begin
                        dsr_MINUS <= rnw_q;
                        dsw_MINUS <= !rnw_q;
                        state     <= M_REL;
                    end else if (tmo_cnt == TMO_LAST) begin
                        error <= 1'b1;
                        state <= M_ERR;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                M_REL: begin
                    tmo_cnt <= '0;
                    state   <= M_WRACK;
                end
                M_WRACK: begin
                    if (dtack_MINUS) begin
                        done        <= 1'b1;
                        cycle_count <= cycle_count + CNT_W'(1);
                        state       <= M_FIN;
                    end else if (tmo_cnt == TMO_LAST) begin
                        error <= 1'b1;
                        state <= M_ERR;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                M_FIN: begin
                    busy  <= 1'b0;
                    state <= M_IDLE;
                end
                M_ERR: begin
                    error <= 1'b1;
                end
                default: begin
                    error <= 1'b1;
                    state <= M_ERR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vme_env_sync.sv
// ---------------------------------------------------------------------------
// tb_vme_env_sync
// Directed bench acting as the VME controller model around vme_env_sync.
// Inputs change 1ns after a rising edge; outputs are read at that same point.
// ---------------------------------------------------------------------------
module tb_vme_env_sync;
    import vme_env_pkg::*;

    localparam int DLY = 2;
    localparam int TMO = 8;
    localparam int CW  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start, rnw;
    logic          d_PLUS, d_MINUS, lds_PLUS, lds_MINUS, dtack_PLUS, dtack_MINUS;
    logic          dsr_PLUS, dsr_MINUS, dsw_PLUS, dsw_MINUS;
    logic          ldtack_PLUS, ldtack_MINUS;
    logic          busy, done, error;
    logic [CW-1:0] cycle_count;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int dsr_cnt  = 0;
    int ldp_cnt  = 0;
    int snap;
    err_cause_t scen;

    always #5 clk = ~clk;

    vme_env_sync #(
        .LDTACK_DLY(DLY),
        .TIMEOUT   (TMO),
        .CNT_W     (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .rnw         (rnw),
        .d_PLUS      (d_PLUS),
        .d_MINUS     (d_MINUS),
        .lds_PLUS    (lds_PLUS),
        .lds_MINUS   (lds_MINUS),
        .dtack_PLUS  (dtack_PLUS),
        .dtack_MINUS (dtack_MINUS),
        .dsr_PLUS    (dsr_PLUS),
        .dsr_MINUS   (dsr_MINUS),
        .dsw_PLUS    (dsw_PLUS),
        .dsw_MINUS   (dsw_MINUS),
        .ldtack_PLUS (ldtack_PLUS),
        .ldtack_MINUS(ldtack_MINUS),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .cycle_count (cycle_count)
    );

    // Pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (dsr_PLUS || dsr_MINUS) dsr_cnt++;
        if (ldtack_PLUS) ldp_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s [%s] observed=%0h expected=%0h", tag, scen.name(), obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // One full bus cycle as a well-behaved controller would drive it.
    task automatic do_cycle(input logic rd, input bit chk);
        start = 1'b1;
        rnw   = rd;
        tick();
        start = 1'b0;
        if (chk) begin
            check(rd ? "dsr_plus" : "dsw_plus", 32'(rd ? dsr_PLUS : dsw_PLUS), 32'd1);
            check("busy_req", 32'(busy), 32'd1);
        end
        if (rd) begin
            lds_PLUS = 1'b1;
            tick();
            lds_PLUS = 1'b0;
            if (chk) check("ldtp_dly0", 32'(ldtack_PLUS), 32'd0);
            tick();
            if (chk) check("ldtp_dly1", 32'(ldtack_PLUS), 32'd0);
            tick();
            if (chk) check("ldtp_dly2", 32'(ldtack_PLUS), 32'd1);
            d_PLUS = 1'b1;
            tick();
            d_PLUS = 1'b0;
        end else begin
            d_PLUS = 1'b1;
            tick();
            d_PLUS   = 1'b0;
            lds_PLUS = 1'b1;
            tick();
            lds_PLUS = 1'b0;
            ticks(2);
            if (chk) check("ldtp_wr", 32'(ldtack_PLUS), 32'd1);
            d_MINUS = 1'b1;
            tick();
            d_MINUS = 1'b0;
        end
        dtack_PLUS = 1'b1;
        tick();
        dtack_PLUS = 1'b0;
        if (chk) check(rd ? "dsr_minus" : "dsw_minus", 32'(rd ? dsr_MINUS : dsw_MINUS), 32'd1);
        if (rd) begin
            d_MINUS = 1'b1;
            tick();
            d_MINUS = 1'b0;
        end else begin
            tick();
        end
        dtack_MINUS = 1'b1;
        tick();
        dtack_MINUS = 1'b0;
        if (chk) check("done_fin", 32'(done), 32'd1);
        lds_MINUS = 1'b1;
        tick();
        lds_MINUS = 1'b0;
        if (chk) begin
            check("done_after", 32'(done), 32'd0);
            check("busy_idle", 32'(busy), 32'd0);
        end
        ticks(2);
        if (chk) check("ldtm", 32'(ldtack_MINUS), 32'd1);
    endtask

    initial begin
        scen        = ERR_NONE;
        reset       = 1'b1;
        start       = 1'b0;
        rnw         = 1'b0;
        d_PLUS      = 1'b0;
        d_MINUS     = 1'b0;
        lds_PLUS    = 1'b0;
        lds_MINUS   = 1'b0;
        dtack_PLUS  = 1'b0;
        dtack_MINUS = 1'b0;
        ticks(2);
        check("reset_outs", 32'({dsr_PLUS, dsr_MINUS, dsw_PLUS, dsw_MINUS, ldtack_PLUS,
                                 ldtack_MINUS, busy, done, error}), 32'd0);
        check("reset_count", 32'(cycle_count), 32'd0);
        reset = 1'b0;
        tick();

        // Read cycle
        do_cycle(1'b1, 1'b1);
        check("rd_count", 32'(cycle_count), 32'd1);
        check("rd_error", 32'(error), 32'd0);
        check("rd_done_pulses", done_cnt, 32'd1);

        // Write cycle: no dsr activity allowed
        snap = dsr_cnt;
        do_cycle(1'b0, 1'b1);
        check("wr_count", 32'(cycle_count), 32'd2);
        check("wr_error", 32'(error), 32'd0);
        check("wr_no_dsr", dsr_cnt, snap);
        check("wr_done_pulses", done_cnt, 32'd2);

        // Timeout: no dtack ever
        scen  = ERR_TIMEOUT;
        snap  = done_cnt;
        start = 1'b1;
        rnw   = 1'b1;
        tick();
        start = 1'b0;
        tick();       // entered WACK
        ticks(TMO - 1);
        check("tmo_before", 32'(error), 32'd0);
        tick();
        check("tmo_error", 32'(error), 32'd1);
        check("tmo_busy", 32'(busy), 32'd1);
        ticks(5);
        check("tmo_sticky", 32'(error), 32'd1);
        check("tmo_busy_hold", 32'(busy), 32'd1);
        check("tmo_no_done", done_cnt, snap);
        do_reset();
        check("tmo_reset_err", 32'(error), 32'd0);
        check("tmo_reset_busy", 32'(busy), 32'd0);

        // Protocol violation: lds_PLUS while device HI
        scen     = ERR_LDS;
        lds_PLUS = 1'b1;
        tick();
        lds_PLUS = 1'b0;
        ticks(2);
        check("pv_ldtp", 32'(ldtack_PLUS), 32'd1);
        tick();
        check("pv_err_before", 32'(error), 32'd0);
        snap     = ldp_cnt;
        lds_PLUS = 1'b1;
        tick();
        lds_PLUS = 1'b0;
        check("pv_error", 32'(error), 32'd1);
        ticks(5);
        check("pv_no_extra_ldtp", ldp_cnt, snap);
        do_reset();

        // Reset one cycle before the scheduled ldtack_PLUS
        scen  = ERR_NONE;
        snap  = ldp_cnt;
        start = 1'b1;
        rnw   = 1'b1;
        tick();
        start    = 1'b0;
        lds_PLUS = 1'b1;
        tick();
        lds_PLUS = 1'b0;
        tick();
        #2 reset = 1'b1;
        #1;
        check("rst_async_outs", 32'({dsr_PLUS, dsr_MINUS, dsw_PLUS, dsw_MINUS, ldtack_PLUS,
                                     ldtack_MINUS, busy, done, error}), 32'd0);
        tick();
        check("rst_no_ldtp", 32'(ldtack_PLUS), 32'd0);
        check("rst_count", 32'(cycle_count), 32'd0);
        reset = 1'b0;
        ticks(3);
        check("rst_ldtp_cancel", ldp_cnt, snap);
        do_cycle(1'b1, 1'b1);
        check("rst_read_count", 32'(cycle_count), 32'd1);
        check("rst_read_error", 32'(error), 32'd0);

        // Counter wrap with CNT_W=4
        do_reset();
        snap = done_cnt;
        for (int i = 0; i < 15; i++) do_cycle(1'b1, 1'b0);
        check("wrap_15", 32'(cycle_count), 32'd15);
        do_cycle(1'b1, 1'b0);
        check("wrap_0", 32'(cycle_count), 32'd0);
        check("wrap_done16", done_cnt - snap, 32'd16);
        check("wrap_error", 32'(error), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vme_env_sync.md
Name: vme_env_sync

Overview:
- Synchronous environment for the clocked VME bus controller (multi-FSM Mealy decomposition).
- Acts as the other end of both controller interfaces:
  - bus master: issues read/write cycles via dsr/dsw events and waits for dtack events;
  - device responder: answers lds events with ldtack events after a programmable delay.
- Includes a protocol checker on the controller outputs.
- Used as the closed-loop partner in system sims and on FPGA test harnesses.

Parameters:
- LDTACK_DLY, 2, cycles from a sampled lds event to the matching ldtack pulse (legal range 1..15).
- TIMEOUT, 255, max cycles the master waits for a dtack event before flagging error (8-bit counter).
- CNT_W, 16, width of the completed-cycle counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request one bus cycle; sampled only in IDLE.
- rnw  in  1  1 = read cycle (dsr), 0 = write cycle (dsw); latched with start.
- d_PLUS, d_MINUS  in  1 each  controller data-enable events (one-cycle pulses).
- lds_PLUS, lds_MINUS  in  1 each  controller device-strobe events.
- dtack_PLUS, dtack_MINUS  in  1 each  controller acknowledge events.
- dsr_PLUS, dsr_MINUS, dsw_PLUS, dsw_MINUS  out  1 each  master request events, registered one-cycle pulses.
- ldtack_PLUS, ldtack_MINUS  out  1 each  device acknowledge events, registered one-cycle pulses.
- busy  out  1  master not in IDLE.
- done  out  1  one-cycle pulse on completed bus cycle.
- error  out  1  sticky; timeout or protocol violation.
- cycle_count  out  CNT_W  number of completed cycles, wraps modulo 2^CNT_W.

Behaviour:
- Reset (async, active-high): all event outputs 0; busy 0; done 0; error 0; cycle_count 0; master FSM in IDLE; device FSM in LO; delay and timeout counters 0.
- Master FSM states: IDLE, REQ, WACK, REL, WRACK, FIN, ERR.
  - IDLE: on start=1, latch rnw and go to REQ.
  - REQ: one cycle. Pulse dsr_PLUS (read) or dsw_PLUS (write). Go to WACK.
  - WACK: wait for dtack_PLUS, then go to REL. Timeout counter increments each cycle; at TIMEOUT go to ERR.
  - REL: one cycle. Pulse dsr_MINUS or dsw_MINUS. Go to WRACK.
  - WRACK: wait for dtack_MINUS, then go to FIN. Same timeout rule as WACK.
  - FIN: one cycle. done=1, cycle_count+1. Go to IDLE.
  - ERR: error=1; remains in ERR until reset.
  - Latency: start to dsr_PLUS/dsw_PLUS is 1 cycle (REQ is registered, so the pulse appears the cycle after start is sampled).
  - A dtack event arriving in the same cycle as the REQ or REL pulse is not accepted until the next state; it is recorded as early_ack and sets error.
- Device FSM states: LO, RISE, HI, FALL.
  - LO: on lds_PLUS, load delay counter with LDTACK_DLY and go to RISE.
  - RISE: decrement the counter. On reaching 0, pulse ldtack_PLUS and go to HI. The pulse is exactly LDTACK_DLY cycles after the cycle in which lds_PLUS was sampled.
  - HI: on lds_MINUS, go to FALL (symmetric to RISE).
  - FALL: on reaching 0, pulse ldtack_MINUS and go to LO.
  - The device FSM runs independently of the master FSM, including while the master is in ERR.
- Protocol checker (sets the sticky error):
  - lds_PLUS outside LO, or lds_MINUS outside HI;
  - both PLUS and MINUS of the same signal in one cycle;
  - dtack_PLUS outside WACK, or dtack_MINUS outside WRACK;
  - read cycle: dtack_PLUS before d_PLUS within the current cycle;
  - write cycle: d_PLUS not seen before lds_PLUS.
  - A d event-state flag is cleared in IDLE.
- Simultaneous events:
  - lds_MINUS in the same cycle as the ldtack_PLUS pulse is treated as arriving in HI and is accepted.
  - start while busy is ignored.
- Reset mid-cycle forces all FSMs and outputs to their reset values immediately; any pending ldtack pulse is cancelled.

Decomposition:
- Package vme_env_pkg holds:
  - master_state_t and dev_state_t enums;
  - the TIMEOUT default;
  - an error-cause code enum, for the bench only.
- One sub-module, vme_dev_resp: the device FSM with its delay counter. It is instantiated once.
- The master FSM, protocol checker and counter live in the top level.

Test Plan:
- Read, LDTACK_DLY=2, model controller: start=1, rnw=1 → dsr_PLUS 1 cycle later; ldtack_PLUS 2 cycles after lds_PLUS; done pulses once; cycle_count=1; error=0.
- Write: start=1, rnw=0 → dsw_PLUS, then dsw_MINUS after dtack_PLUS; done once; cycle_count increments; no dsr pulses at any time.
- Timeout, TIMEOUT=8: controller never sends dtack_PLUS → after 8 cycles in WACK, state is ERR, error=1, busy stays 1, done never pulses.
- Protocol violation: inject lds_PLUS while device is HI → error=1 on the next edge; no extra ldtack_PLUS.
- Reset mid-cycle: assert reset 1 cycle before the scheduled ldtack_PLUS → no ldtack_PLUS, all outputs 0, cycle_count=0; a subsequent read completes normally.
- Wrap, CNT_W=4: 16 back-to-back reads → cycle_count returns to 0; done pulses 16 times.
